// File: rtl/sort_pkg.sv
// Shared types and default sizes for the stream sort host and its sorter.
package sort_pkg;

    localparam int SORT_N     = 6;
    localparam int SORT_WIDTH = 8;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        UNLOAD
    } host_state_t;

endpackage

// File: rtl/sort_stream_host.sv
// Collects N stream words into a frame, hands it to an external sorter,
// then streams the sorted frame back out in ascending order.
module sort_stream_host
    import sort_pkg::*;
#(
    parameter int N       = SORT_N,
    parameter int WIDTH   = SORT_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             sort_start,
    output logic [WIDTH-1:0] sort_data [N],
    input  logic             sort_done,
    input  logic [WIDTH-1:0] sort_result [N],
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             err_timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    host_state_t      state_q, state_d;
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ld_en, cap_en;
    logic [WIDTH-1:0] data_q [N];
    logic [WIDTH-1:0] buf_q  [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
                buf_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            if (ld_en)
                data_q[wr_idx_q] <= s_data;
            if (cap_en)
                for (int i = 0; i < N; i++)
                    buf_q[i] <= sort_result[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ld_en    = 1'b0;
        cap_en   = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (s_valid) begin
                    ld_en = 1'b1;
                    if (wr_idx_q == LAST) begin
                        wr_idx_d = '0;
                        state_d  = ISSUE;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // cnt_d equals the WAIT cycle number; done beats timeout
                cnt_d = (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
                if (sort_done) begin
                    cap_en   = 1'b1;
                    rd_idx_d = '0;
                    state_d  = UNLOAD;
                end else if (cnt_d == TMAX) begin
                    err_d    = 1'b1;
                    wr_idx_d = '0;
                    state_d  = LOAD;
                end
            end
            UNLOAD: begin
                if (m_ready) begin
                    if (rd_idx_q == LAST) begin
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign s_ready     = (state_q == LOAD);
    assign sort_start  = (state_q == ISSUE);
    assign m_valid     = (state_q == UNLOAD);
    assign m_data      = buf_q[rd_idx_q];
    assign m_last      = m_valid && (rd_idx_q == LAST);
    assign busy        = (state_q != LOAD);
    assign err_timeout = err_q;
    assign sort_data   = data_q;

endmodule
